// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock, LSB digit first,
// through a registered carry. Start/busy/done handshake with signed-overflow flag.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] work_next;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [DIGIT-1:0] a_digits [N];
  logic [DIGIT-1:0] b_digits [N];
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   sum_digit;
  logic             last_digit;
  logic             v_next;

  // Split the latched operands into digits and merge the current digit's sum
  // into the working result.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_digit
      localparam logic [IDX_W-1:0] IDX_GI = IDX_W'(gi);
      assign a_digits[gi] = op_a_reg[gi*DIGIT +: DIGIT];
      assign b_digits[gi] = op_b_reg[gi*DIGIT +: DIGIT];
      assign work_next[gi*DIGIT +: DIGIT] =
        (idx_reg == IDX_GI) ? sum_digit[DIGIT-1:0] : work_reg[gi*DIGIT +: DIGIT];
    end

    if (N == 1) begin : g_single
      assign a_dig = a_digits[0];
      assign b_dig = b_digits[0];
    end else begin : g_multi
      assign a_dig = a_digits[idx_reg];
      assign b_dig = b_digits[idx_reg];
    end
  endgenerate

  assign sum_digit  = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(carry_reg);
  assign last_digit = (idx_reg == LAST_IDX);

  // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
  assign v_next = sum_digit[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum_digit[DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      work_reg  <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      S         <= '0;
      C_out     <= 1'b0;
      V         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_a_reg  <= A;
            op_b_reg  <= Sub ? ~B : B;
            carry_reg <= Sub ? ~C_in : C_in;
            idx_reg   <= '0;
            work_reg  <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          work_reg  <= work_next;
          carry_reg <= sum_digit[DIGIT];
          if (last_digit) begin
            S         <= work_next;
            C_out     <= sum_digit[DIGIT];
            V         <= v_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            idx_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (DIGIT=4, 16, 1) share operand
// inputs; expected results are queued at issue and popped by a monitor on done.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B;
  logic        C_in, Sub;
  logic        start0, start1, start2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [15:0] S0, S1, S2;
  logic        C0, C1, C2;
  logic        V0, V1, V2;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start0), .A(A), .B(B), .C_in(C_in), .Sub(Sub),
    .busy(busy0), .done(done0), .S(S0), .C_out(C0), .V(V0));

  serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .start(start1), .A(A), .B(B), .C_in(C_in), .Sub(Sub),
    .busy(busy1), .done(done1), .S(S1), .C_out(C1), .V(V1));

  serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .A(A), .B(B), .C_in(C_in), .Sub(Sub),
    .busy(busy2), .done(done2), .S(S2), .C_out(C2), .V(V2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic compare_out(input string tag, input exp_t e,
                             input logic [15:0] s, input logic c, input logic v);
    chk({tag, " S"}, 32'(s), 32'(e.s));
    chk({tag, " C_out"}, 32'(c), 32'(e.c));
    chk({tag, " V"}, 32'(v), 32'(e.v));
    chk({tag, " done cycle"}, 32'(cyc), 32'(e.due));
  endtask

  task automatic unexpected_done(input string tag);
    checks++;
    errors++;
    $display("FAIL %s unexpected done: got done=1, expected done=0 (cycle %0d)", tag, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) unexpected_done("dut4");
      else begin e = q0.pop_front(); compare_out("dut4", e, S0, C0, V0); end
    end
    if (done1) begin
      if (q1.size() == 0) unexpected_done("dut16");
      else begin e = q1.pop_front(); compare_out("dut16", e, S1, C1, V1); end
    end
    if (done2) begin
      if (q2.size() == 0) unexpected_done("dut1");
      else begin e = q2.pop_front(); compare_out("dut1", e, S2, C2, V2); end
    end
  end

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qclear(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Issue one operation to instance d (0: DIGIT=4, 1: DIGIT=16, 2: DIGIT=1).
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       input logic [15:0] es, input logic ec, input logic ev);
    exp_t e;
    int   n;
    logic bsy;
    n = (d == 0) ? 4 : (d == 1) ? 1 : 16;
    A = a; B = b; C_in = cin; Sub = sub;
    case (d)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    e.s = es; e.c = ec; e.v = ev; e.due = cyc + 1 + n;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bsy = (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
    chk($sformatf("busy after accept d%0d", d), 32'(bsy), 32'd1);
    A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom); Sub = 1'($urandom);
  endtask

  task automatic wait_drain(input int d);
    for (int i = 0; i < 40; i++) begin
      if (qsize(d) == 0) break;
      @(negedge clk); #1;
    end
    if (qsize(d) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain d%0d: got %0d outstanding results, expected 0", d, qsize(d));
      qclear(d);
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    A = 16'($urandom); B = 16'($urandom); C_in = 1'b1; Sub = 1'b0;
    repeat (2) begin
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom);
    end
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk("reset S", 32'(S0), 32'h0000);
    chk("reset C_out", 32'(C0), 32'd0);
    chk("reset V", 32'(V0), 32'd0);
    chk("reset busy dut16", 32'(busy1), 32'd0);
    chk("reset busy dut1", 32'(busy2), 32'd0);
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    chk("idle after reset", 32'(busy0), 32'd0);

    // Basic add, then result holds after done.
    issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    wait_drain(0);
    repeat (3) @(negedge clk);
    chk("S holds after done", 32'(S0), 32'h5555);

    // Carry, overflow and carry-in.
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); wait_drain(0);
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); wait_drain(0);
    issue(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0); wait_drain(0);

    // Subtract, including borrow-in.
    issue(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0); wait_drain(0);
    issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); wait_drain(0);
    issue(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0); wait_drain(0);

    // start while busy is ignored.
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      A = 16'($urandom); B = 16'($urandom); start0 = 1'b1;
      @(negedge clk);
    end
    start0 = 1'b0;
    wait_drain(0);

    // Back-to-back: new start in the done cycle.
    issue(0, 16'h0100, 16'h0023, 1'b1, 1'b0, 16'h0124, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (done0) break;
    end
    chk("done seen before back-to-back", 32'(done0), 32'd1);
    issue(0, 16'h7000, 16'h7000, 1'b0, 1'b0, 16'hE000, 1'b0, 1'b1);
    wait_drain(0);

    // Abort with rst at cycle 2; start together with rst must be ignored.
    issue(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; start0 = 1'b1; A = 16'h4444; B = 16'h4444;
    qclear(0);
    @(negedge clk);
    chk("abort busy", 32'(busy0), 32'd0);
    chk("abort done", 32'(done0), 32'd0);
    chk("abort S", 32'(S0), 32'h0000);
    chk("abort C_out", 32'(C0), 32'd0);
    chk("abort V", 32'(V0), 32'd0);
    rst = 1'b0; start0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle after abort", 32'(busy0), 32'd0);
    issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0); wait_drain(0);

    // Same vectors at DIGIT=16 and DIGIT=1.
    issue(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0); wait_drain(1);
    issue(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); wait_drain(1);
    issue(2, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0); wait_drain(2);
    issue(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); wait_drain(2);
    issue(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0); wait_drain(2);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
